// File: rtl/x_delay_arb.sv
`default_nettype none
// ============================================================================
// Module   : x_delay_arb
// Brief    : NREQ edge-triggered requesters sharing one round-robin countdown
//            engine. Each granted request yields a delayed one-clock strobe.
// Revision : 1.0 - initial release
// ============================================================================
module x_delay_arb #(
    parameter int NREQ  = 4,
    parameter int MXDLY = 4,
    parameter int MXID  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       d,
    input  logic [NREQ*MXDLY-1:0] delay,
    input  logic                  clr_ovf,
    output logic [NREQ-1:0]       q,
    output logic                  busy,
    output logic [MXID-1:0]       grant_id,
    output logic [NREQ-1:0]       ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_FIRE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [NREQ-1:0]  r_pend;
    logic [NREQ-1:0]  r_inhibit;
    logic [NREQ-1:0]  r_ovf;
    logic [NREQ-1:0]  r_q;
    logic             r_busy;
    logic [MXID-1:0]  r_grant;
    logic [MXID-1:0]  r_rr;
    logic [MXDLY-1:0] r_cnt;

    logic [NREQ-1:0]  w_trig;
    logic [NREQ-1:0]  w_clr;
    logic [NREQ-1:0]  w_ovf_set;
    logic [NREQ-1:0]  w_rot;
    logic [MXID:0]    w_off;
    logic [MXID:0]    w_sum;
    logic [MXID-1:0]  w_sel;
    logic [MXID-1:0]  w_rr_next;
    logic             w_found;
    logic [MXDLY-1:0] w_dly [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_dly
            assign w_dly[gi] = delay[gi*MXDLY +: MXDLY];
        end
    endgenerate

    assign w_trig  = d & ~r_inhibit;
    assign w_found = |r_pend;

    // Rotate pending so the rr pointer sits at bit 0, take the lowest set bit,
    // then rotate the winning offset back into a channel index.
    always_comb begin
        w_rot = NREQ'({r_pend, r_pend} >> r_rr);
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = (MXID+1)'(k);
            end
        end
        w_sum = {1'b0, r_rr} + w_off;
        if (w_sum >= (MXID+1)'(NREQ)) begin
            w_sum = w_sum - (MXID+1)'(NREQ);
        end
        w_sel = MXID'(w_sum);
    end

    assign w_rr_next = (r_grant == MXID'(NREQ - 1)) ? '0 : r_grant + 1'b1;
    assign w_clr     = (r_state == S_IDLE && w_found) ? (NREQ'(1) << w_sel) : '0;
    // A trigger landing on the grant edge re-queues instead of overflowing.
    assign w_ovf_set = w_trig & r_pend & ~w_clr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_COUNT;
            S_COUNT: if (r_cnt == '0) w_next = S_FIRE;
            S_FIRE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pend    <= '0;
            r_inhibit <= '0;
            r_ovf     <= '0;
            r_q       <= '0;
            r_busy    <= 1'b0;
            r_grant   <= '0;
            r_rr      <= '0;
            r_cnt     <= '0;
        end else begin
            r_inhibit <= d;
            r_pend    <= (r_pend & ~w_clr) | w_trig;
            r_ovf     <= (clr_ovf ? '0 : r_ovf) | w_ovf_set;
            r_state   <= w_next;
            r_busy    <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    r_q <= '0;
                    if (w_found) begin
                        r_grant <= w_sel;
                        r_cnt   <= w_dly[w_sel];
                    end
                end
                S_COUNT: begin
                    if (r_cnt == '0) begin
                        r_q <= NREQ'(1) << r_grant;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIRE: begin
                    r_q  <= '0;
                    r_rr <= w_rr_next;
                end
                default: r_q <= '0;
            endcase
        end
    end

    assign q        = r_q;
    assign busy     = r_busy;
    assign grant_id = r_grant;
    assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_x_delay_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_x_delay_arb
// Brief    : Self-checking bench for x_delay_arb: vector table, directed corner
//            sequences and random traffic against a timestamp-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_x_delay_arb;
    localparam int NREQ  = 4;
    localparam int MXDLY = 4;
    localparam int MXID  = 2;

    logic                  clock   = 1'b0;
    logic                  reset   = 1'b1;
    logic [NREQ-1:0]       d       = '0;
    logic [NREQ*MXDLY-1:0] delay   = '0;
    logic                  clr_ovf = 1'b0;
    logic [NREQ-1:0]       q;
    logic                  busy;
    logic [MXID-1:0]       grant_id;
    logic [NREQ-1:0]       ovf;

    x_delay_arb #(.NREQ(NREQ), .MXDLY(MXDLY), .MXID(MXID)) dut (
        .clock    (clock),
        .reset    (reset),
        .d        (d),
        .delay    (delay),
        .clr_ovf  (clr_ovf),
        .q        (q),
        .busy     (busy),
        .grant_id (grant_id),
        .ovf      (ovf)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: events are timestamps (grant edge, fire edge, first
    // idle edge) rather than a state machine.
    logic [NREQ-1:0] m_pend, m_ovf, m_prev;
    int              m_rr, m_owner, m_fire, m_idle_from, m_n;
    logic [NREQ-1:0] e_q, e_ovf;
    logic            e_busy;
    int              e_gid;

    int pulse_cnt   [NREQ];
    int first_pulse [NREQ];
    int last_pulse  [NREQ];

    typedef struct {
        logic [NREQ-1:0] d;
        logic [NREQ-1:0] q;
        logic            busy;
        int              gid;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_ovf = '0; m_prev = '0;
        m_rr = 0; m_owner = 0; m_fire = -1; m_idle_from = 0;
        e_q = '0; e_busy = 1'b0; e_gid = 0; e_ovf = '0;
    endtask

    task automatic model_step();
        logic [NREQ-1:0] trig, clr;
        int sel, dly;
        if (reset) begin
            model_reset();
            m_n++;
            return;
        end
        trig = d & ~m_prev;
        clr  = '0;
        if (m_n >= m_idle_from && m_pend != '0) begin
            sel = -1;
            for (int k = 0; k < NREQ; k++)
                if (sel < 0 && ((m_pend >> ((m_rr + k) % NREQ)) & 1) != 0)
                    sel = (m_rr + k) % NREQ;
            dly         = int'(MXDLY'(delay >> (sel * MXDLY)));
            m_owner     = sel;
            m_fire      = m_n + dly + 1;
            m_idle_from = m_n + dly + 3;
            m_rr        = (sel + 1) % NREQ;
            clr         = NREQ'(1) << sel;
        end
        m_ovf  = (clr_ovf ? '0 : m_ovf) | (trig & m_pend & ~clr);
        m_pend = (m_pend & ~clr) | trig;
        m_prev = d;
        e_q    = (m_n == m_fire) ? (NREQ'(1) << m_owner) : '0;
        e_busy = (m_n + 1 < m_idle_from);
        e_gid  = m_owner;
        e_ovf  = m_ovf;
        m_n++;
    endtask

    task automatic check_model();
        chk("q",        int'(q),        int'(e_q));
        chk("busy",     int'(busy),     int'(e_busy));
        chk("grant_id", int'(grant_id), e_gid);
        chk("ovf",      int'(ovf),      int'(e_ovf));
    endtask

    task automatic clear_log();
        for (int i = 0; i < NREQ; i++) begin
            pulse_cnt[i] = 0; first_pulse[i] = -1; last_pulse[i] = -1;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        cyc++;
        check_model();
        for (int i = 0; i < NREQ; i++) begin
            if (((q >> i) & 1) != 0) begin
                pulse_cnt[i]++;
                if (first_pulse[i] < 0) first_pulse[i] = cyc;
                last_pulse[i] = cyc;
            end
        end
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((m_pend != '0 || e_busy) && n < max) begin
            step();
            n++;
        end
        if (n >= max) chk("drain_timeout", 1, 0);
    endtask

    task automatic async_reset(input int hold);
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_async_q",    int'(q),    0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_ovf",  int'(ovf),  0);
        repeat (hold) step();
        reset = 1'b0;
    endtask

    int e0;

    initial begin
        model_reset();
        m_n = 0;
        clear_log();

        tbl[0]  = '{4'b0100, 4'b0000, 1'b0, 0};
        tbl[1]  = '{4'b0100, 4'b0000, 1'b1, 2};
        tbl[2]  = '{4'b0100, 4'b0000, 1'b1, 2};
        tbl[3]  = '{4'b0100, 4'b0000, 1'b1, 2};
        tbl[4]  = '{4'b0100, 4'b0000, 1'b1, 2};
        tbl[5]  = '{4'b0100, 4'b0000, 1'b1, 2};
        tbl[6]  = '{4'b0100, 4'b0000, 1'b1, 2};
        tbl[7]  = '{4'b0100, 4'b0100, 1'b1, 2};
        tbl[8]  = '{4'b0100, 4'b0000, 1'b0, 2};
        tbl[9]  = '{4'b0100, 4'b0000, 1'b0, 2};
        tbl[10] = '{4'b0000, 4'b0000, 1'b0, 2};
        tbl[11] = '{4'b0000, 4'b0000, 1'b0, 2};

        // Reset state
        delay = {4{4'd5}};
        step(); step();
        chk("rst_q", int'(q), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_gid", int'(grant_id), 0);
        chk("rst_ovf", int'(ovf), 0);
        reset = 1'b0;
        step(); step();

        // Single event, delay 5 on channel 2
        for (int k = 0; k < 12; k++) begin
            d = tbl[k].d;
            step();
            chk("tbl_q",    int'(q),        int'(tbl[k].q));
            chk("tbl_busy", int'(busy),     int'(tbl[k].busy));
            chk("tbl_gid",  int'(grant_id), tbl[k].gid);
            chk("tbl_ovf",  int'(ovf),      0);
        end

        // Collision and round-robin, all delays 1, rr starts at 0
        async_reset(2);
        delay = {4{4'd1}};
        clear_log();
        d = 4'b1001; step(); e0 = cyc; step(); d = '0; drain(50);
        chk("coll_ch0_time", first_pulse[0], e0 + 3);
        chk("coll_ch3_time", first_pulse[3], e0 + 7);
        chk("coll_ch0_cnt", pulse_cnt[0], 1);
        chk("coll_ch3_cnt", pulse_cnt[3], 1);
        clear_log();
        d = 4'b1001; step(); e0 = cyc; step(); d = '0; drain(50);
        chk("rr_wrap_ch0_first", first_pulse[0], e0 + 3);
        chk("rr_wrap_ch3_second", first_pulse[3], e0 + 7);
        d = 4'b0001; step(); d = '0; drain(50);
        clear_log();
        d = 4'b1001; step(); e0 = cyc; step(); d = '0; drain(50);
        chk("rr1_ch3_first", first_pulse[3], e0 + 3);
        chk("rr1_ch0_second", first_pulse[0], e0 + 7);

        // Overflow on channel 1 while channel 0 counts
        delay = {4'd1, 4'd1, 4'd15, 4'd10};
        clear_log();
        d = 4'b0001; step(); step();
        for (int r = 0; r < 3; r++) begin
            d = 4'b0010; step();
            d = 4'b0000; step();
        end
        chk("ovf1_set", int'(ovf[1]), 1);
        drain(100);
        chk("ovf1_pulses", pulse_cnt[1], 1);
        chk("ovf0_pulses", pulse_cnt[0], 1);
        chk("ovf1_sticky", int'(ovf[1]), 1);
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        chk("ovf1_cleared", int'(ovf[1]), 0);

        // Set wins over grant-clear on channel 2
        delay = {4'd1, 4'd2, 4'd1, 4'd3};
        clear_log();
        for (int k = 0; k < 10; k++) begin
            d = {1'b0, (k == 2 || k == 7 || k == 8), 1'b0, (k < 2)};
            step();
            if (k == 0) e0 = cyc;
        end
        d = '0; drain(60);
        chk("setwin_ovf2", int'(ovf[2]), 0);
        chk("setwin_cnt2", pulse_cnt[2], 2);
        chk("setwin_first", first_pulse[2], e0 + 10);
        chk("setwin_spacing", last_pulse[2] - first_pulse[2], 5);

        // Delay sampled only at grant
        delay = {4'd1, 4'd1, 4'd1, 4'd3};
        clear_log();
        d = 4'b0001; step(); e0 = cyc; step(); step();
        delay = {4'd1, 4'd1, 4'd1, 4'd12};
        d = '0; drain(60);
        chk("dly_sample_time", first_pulse[0], e0 + 5);
        chk("dly_sample_cnt", pulse_cnt[0], 1);

        // Reset in COUNT with two channels pending and an overflow set
        delay = {4{4'd8}};
        d = 4'b0001; step(); step();
        d = 4'b0110; step();
        d = 4'b0000; step();
        d = 4'b0010; step();
        d = 4'b0000; step(); step();
        chk("pre_rst_ovf1", int'(ovf[1]), 1);
        chk("pre_rst_busy", int'(busy), 1);
        async_reset(2);
        clear_log();
        repeat (40) step();
        chk("post_rst_pulses", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], 0);
        chk("post_rst_busy", int'(busy), 0);
        d = 4'b0010;
        async_reset(2);
        clear_log();
        step(); step();
        drain(60);
        chk("rst_release_d1", pulse_cnt[1], 1);
        chk("rst_release_others", pulse_cnt[0] + pulse_cnt[2] + pulse_cnt[3], 0);
        d = '0; step(); drain(60);

        // Random traffic against the model
        for (int it = 0; it < 4000; it++) begin
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(0, 5) == 0) d = d ^ (NREQ'(1) << b);
            if ($urandom_range(0, 15) == 0) delay = (NREQ*MXDLY)'($urandom);
            clr_ovf = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 599) == 0) async_reset(1);
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
